// File: rtl/urisc_memsys.sv
// Unified 256x8 program/data RAM for the ultimate-RISC core, with a byte-stream
// boot loader that holds the CPU in reset, plus a memory-mapped output port.
module urisc_memsys #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] OUT_ADDR  = '1,
  parameter int                BOOT_HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_reset,
  output logic              running,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int HOLD_W = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;

  typedef enum logic [1:0] {S_LOAD, S_HOLD, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ld_ptr_q, ld_ptr_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_comb begin
    state_d     = state_q;
    ld_ptr_d    = ld_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = cpu_addr;
    mem_wdata   = cpu_wdata;
    case (state_q)
      S_LOAD: begin
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ld_ptr_q;
          mem_wdata = ld_data;
          // A full RAM ends the load even without ld_last; the pointer never wraps.
          if (ld_last || (&ld_ptr_q)) begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_W'(BOOT_HOLD - 1);
          end else begin
            ld_ptr_d = ld_ptr_q + ADDR_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (cpu_we) begin
          mem_we = 1'b1;
          if (cpu_addr == OUT_ADDR) begin
            out_valid_d = 1'b1;
            out_data_d  = cpu_wdata;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      ld_ptr_q    <= '0;
      hold_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_ptr_q    <= ld_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // RAM contents deliberately survive reset so a partial reload patches low addresses only.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign cpu_rdata = mem[cpu_addr];
  assign ld_ready  = (state_q == S_LOAD);
  assign cpu_reset = (state_q != S_RUN);
  assign running   = (state_q == S_RUN);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_urisc_memsys.sv
// Randomized bench for urisc_memsys: reference RAM model plus an output-port
// scoreboard drained by an independent monitor.
module tb_urisc_memsys;
  localparam int BOOT_HOLD = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic [7:0] cpu_rdata;
  logic       cpu_reset;
  logic       running;
  logic [7:0] out_data;
  logic       out_valid;

  always #5 clk = ~clk;

  urisc_memsys #(.ADDR_W(8), .DATA_W(8), .OUT_ADDR(8'hFF), .BOOT_HOLD(BOOT_HOLD)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .cpu_reset(cpu_reset), .running(running), .out_data(out_data), .out_valid(out_valid)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  exp_t       sb_q[$];
  logic [7:0] ref_mem [256];
  bit         known [256];
  logic [7:0] ld_buf [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_read(input int a);
    cpu_we   = 1'b0;
    cpu_addr = a[7:0];
    #1;
    if (known[a]) check($sformatf("rdata[%02h]", a), cpu_rdata, ref_mem[a]);
  endtask

  task automatic sweep();
    for (int a = 0; a < 256; a++) chk_read(a);
  endtask

  task automatic do_reset(input bit with_ld);
    reset    = 1'b1;
    ld_valid = with_ld;
    ld_data  = 8'h77;
    ld_last  = 1'b1;
    cpu_we   = 1'b0;
    tick();
    check("rst_ld_ready", ld_ready, 1);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_running", running, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    reset    = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // mode 0: no gaps, 1: alternating valid, 2: random gaps
  task automatic load_seq(input int n, input bit use_last, input int mode, input bit blk_we);
    int i = 0;
    int guard = 0;
    bit v;
    bit ph = 1'b1;
    while (i < n && guard < 4000) begin
      guard++;
      case (mode)
        0:       v = 1'b1;
        1:       begin v = ph; ph = !ph; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      ld_valid  = v;
      ld_data   = v ? ld_buf[i] : 8'($urandom);
      ld_last   = v ? (use_last && i == n - 1) : 1'($urandom);
      cpu_we    = blk_we;
      cpu_addr  = 8'h05;
      cpu_wdata = 8'hEE;
      check("ld_ready_load", ld_ready, 1);
      check("cpu_reset_load", cpu_reset, 1);
      tick();
      if (v) begin
        ref_mem[i] = ld_buf[i];
        known[i]   = 1'b1;
        i++;
      end
    end
    if (i < n) check("load_timeout", i, n);
    ld_valid = 1'b1;
    ld_data  = 8'hC3;
    ld_last  = 1'b1;
    for (int k = 0; k < BOOT_HOLD; k++) begin
      check("ld_ready_hold", ld_ready, 0);
      check("cpu_reset_hold", cpu_reset, 1);
      check("running_hold", running, 0);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    cpu_we   = 1'b0;
    check("cpu_reset_run", cpu_reset, 0);
    check("running_run", running, 1);
    check("ld_ready_run", ld_ready, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cpu_we     = 1'b1;
    cpu_addr   = a;
    cpu_wdata  = d;
    ref_mem[a] = d;
    known[a]   = 1'b1;
    if (a == 8'hFF) sb_q.push_back('{data: d, cyc: cyc + 1});
    tick();
  endtask

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        chk_read(int'($urandom_range(0, 255)));
        tick();
      end else begin
        wr(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), 8'($urandom));
      end
    end
    cpu_we = 1'b0;
    tick();
    tick();
  endtask

  // Output-port monitor: every pulse must match the oldest expected write, in its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL out_pulse_missing: no out_valid at cycle %0d, required out_data=%0h", e.cyc, e.data);
      end
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("out_valid_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    tick();
    do_reset(1'b0);

    // Full load without ld_last, random gaps, blocked CPU writes to address 5
    for (int a = 0; a < 256; a++) ld_buf[a] = 8'(a);
    load_seq(256, 1'b0, 2, 1'b1);
    sweep();

    wr(8'h80, 8'h42);
    chk_read(8'h80);
    wr(8'hFF, 8'h07);
    wr(8'hFF, 8'h09);
    cpu_we = 1'b0;
    tick();
    tick();
    run_random(60);
    sweep();

    // Reset mid-run with a coincident loader byte, then a one-byte reload
    do_reset(1'b1);
    chk_read(0);
    ld_buf[0] = 8'h55;
    load_seq(1, 1'b1, 0, 1'b0);
    sweep();
    run_random(30);

    do_reset(1'b0);
    ld_buf[0] = 8'hAA;
    ld_buf[1] = 8'hBB;
    load_seq(2, 1'b1, 1, 1'b1);
    sweep();
    run_random(30);

    do_reset(1'b0);
    ld_buf[0] = 8'h10;
    ld_buf[1] = 8'h20;
    ld_buf[2] = 8'h30;
    load_seq(3, 1'b1, 0, 1'b0);
    sweep();
    run_random(40);
    sweep();

    repeat (3) tick();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/urisc_memsys.md
Name: urisc_memsys

Overview:
- Memory subsystem directly downstream of the ultimate-RISC CPU core.
- Provides the 256x8 unified program/data RAM on the CPU's addr/data_out/we/data_in bus.
- Contains a byte-stream boot loader that fills RAM while holding the CPU in reset.
- Provides a memory-mapped output port so programs can emit results.

Parameters:
- ADDR_W, 8, address width; RAM depth is 2**ADDR_W.
- DATA_W, 8, data width.
- OUT_ADDR, 8'hFF, address whose writes also drive the output port.
- BOOT_HOLD, 2, cycles cpu_reset stays high after loading completes (minimum 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high; returns the block to LOAD.
- ld_valid  input  1  loader byte valid.
- ld_data  input  DATA_W  loader byte.
- ld_last  input  1  marks the final loader byte.
- ld_ready  output  1  block accepts a loader byte this cycle.
- cpu_addr  input  ADDR_W  CPU address bus.
- cpu_wdata  input  DATA_W  CPU write data (the CPU's data_out).
- cpu_we  input  1  CPU write enable.
- cpu_rdata  output  DATA_W  read data to the CPU's data_in.
- cpu_reset  output  1  drives the CPU's synchronous reset.
- running  output  1  high in RUN state.
- out_data  output  DATA_W  last value written to OUT_ADDR.
- out_valid  output  1  one-cycle pulse per write to OUT_ADDR.

Behaviour:
- Clock and reset:
  - clk is the single clock.
  - reset is synchronous, active-high.
  - All control registers update on posedge clk.
- Reset values:
  - state=LOAD, ld_ptr=0, hold_cnt=0.
  - ld_ready=1, cpu_reset=1, running=0, out_data=0, out_valid=0.
  - RAM array is NOT cleared by reset; its contents persist across reset.
- RAM:
  - Read is combinational: cpu_rdata = mem[cpu_addr] in every state, zero cycle latency. The CPU captures data_in in the same cycle it drives addr.
  - Write is synchronous at posedge.
- State machine with states LOAD, HOLD, RUN:
  - LOAD: ld_ready=1, cpu_reset=1.
    - On ld_valid&ld_ready: mem[ld_ptr]<=ld_data and ld_ptr<=ld_ptr+1.
    - If ld_last=1, or ld_ptr==2**ADDR_W-1, go to HOLD with hold_cnt<=BOOT_HOLD-1.
    - ld_ptr never wraps: the 256th byte forces HOLD even when ld_last=0.
    - ld_valid=0 leaves state and ld_ptr unchanged.
  - HOLD: ld_ready=0, cpu_reset=1.
    - hold_cnt decrements each cycle; at hold_cnt==0, go to RUN.
    - Total cpu_reset-high cycles after the last byte equals BOOT_HOLD.
  - RUN: ld_ready=0, cpu_reset=0, running=1.
    - cpu_we=1 writes mem[cpu_addr]<=cpu_wdata.
    - RUN is terminal until reset.
- cpu_we handling: ignored whenever cpu_reset=1 (LOAD/HOLD). ld_ptr is the only RAM write source in LOAD.
- ld_valid outside LOAD is ignored (ld_ready=0); no RAM write occurs.
- Output port, RUN only:
  - A write with cpu_addr==OUT_ADDR also writes RAM normally.
  - Registers out_data<=cpu_wdata.
  - Pulses out_valid=1 in the following cycle.
  - Back-to-back writes give consecutive pulses, each carrying its own data.
- Reset mid-operation:
  - Reset in any state returns to LOAD with ld_ptr=0 and out_valid=0.
  - out_data is cleared.
  - RAM keeps its contents, so a partial reload overwrites only the low addresses.
- Reset and ld_valid in the same cycle: reset wins and no RAM write occurs.
- All outputs except cpu_rdata are registered or decoded from state only; there is no combinational path from ld_* to cpu_*.

Test Plan:
- Boot load, short program:
  - Stimulus: reset, then stream bytes 8'h10,8'h20,8'h30 with ld_last on 8'h30, BOOT_HOLD=2.
  - Required: ld_ready falls the cycle after the last byte; cpu_reset stays high exactly 2 more cycles, then running=1.
  - Required: cpu_addr=0,1,2 reads 10,20,30.
- Loader back-pressure and gaps:
  - Stimulus: ld_valid toggles 1,0,1,0 with bytes AA,BB.
  - Required: mem[0]=AA, mem[1]=BB; ld_ptr unaffected by idle cycles.
- Full-memory load without ld_last:
  - Stimulus: 256 bytes with value=address.
  - Required: HOLD is entered after byte 255; no write to address 0 from wraparound; mem[255]=FF.
- RUN writes and output port:
  - Stimulus: in RUN, cpu_we writes 8'h42 to 8'h80, then 8'h07 and 8'h09 to 8'hFF on consecutive cycles.
  - Required: mem[80]=42 readable the next cycle.
  - Required: out_valid pulses on two consecutive cycles with out_data=07, then 09; no pulse for the 8'h80 write.
- cpu_we blocked during boot:
  - Stimulus: assert cpu_we=1, addr=05, wdata=EE during LOAD/HOLD.
  - Required: mem[5] keeps its loaded value; out_valid stays 0.
- Reset mid-run:
  - Stimulus: reset in RUN, then reload one byte 8'h55 with ld_last.
  - Required: cpu_reset=1 and ld_ready=1 immediately after reset.
  - Required: mem[0]=55 and mem[1..] retain their prior contents.
